// File: rtl/blast_hit_writer.sv
// blast_hit_writer - packs 32-bit ungapped-extension hit records two per 64-bit word
// and writes them to on-chip memory, followed by a header word holding the hit count.
module blast_hit_writer #(
  parameter logic [13:0] BASE_ADDR  = 14'd0,
  parameter logic [15:0] MAX_WORDS  = 16'd1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  CMD_START  = 8'hAA,
  parameter logic [7:0]  CMD_FLUSH  = 8'hBB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        app_ready,
  input  logic [7:0]  app_code,
  input  logic        hit_valid,
  output logic        hit_ready,
  input  logic [7:0]  hit_add_inQ_UnGap,
  input  logic [7:0]  hit_add_inS_UnGap,
  input  logic [7:0]  hit_length_UnGap,
  input  logic [7:0]  hit_add_score,
  input  logic        memory_ready,
  output logic [13:0] memory_address,
  output logic        memory_write,
  output logic [63:0] memory_writedata,
  output logic [7:0]  memory_byteenable,
  output logic        memory_chipselect,
  output logic        memory_clken,
  output logic [15:0] hit_count,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, PART, HDR, DONE} state_t;
  state_t state, state_next;

  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic [31:0] record, pop_record;
  logic [31:0] pack_lo, pack_hi;
  logic        have_lo, pair_full;
  logic [15:0] word_idx;
  logic        start_cmd, flush_cmd, push, pop, word_limit;
  logic        pair_write, part_write;

  assign record     = {hit_add_score, hit_length_UnGap, hit_add_inS_UnGap, hit_add_inQ_UnGap};
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_record = fifo_mem[rd_ptr[AW-1:0]];

  assign start_cmd  = app_ready && (app_code == CMD_START);
  assign flush_cmd  = app_ready && (app_code == CMD_FLUSH) && (state == RUN);
  assign hit_ready  = (state == RUN) && !fifo_full;
  assign push       = hit_valid && hit_ready;
  // A completed pair blocks further pops until its word has been written.
  assign pop        = ((state == RUN) || (state == DRAIN)) && !fifo_empty && !pair_full;
  assign word_limit = (word_idx == MAX_WORDS);

  assign busy              = (state == RUN) || (state == DRAIN) || (state == PART) || (state == HDR);
  assign done              = (state == DONE);
  assign memory_chipselect = memory_write;
  assign memory_clken      = memory_write;

  always_comb begin
    state_next        = state;
    memory_write      = 1'b0;
    memory_address    = 14'd0;
    memory_writedata  = 64'd0;
    memory_byteenable = 8'd0;
    pair_write        = 1'b0;
    part_write        = 1'b0;
    case (state)
      RUN, DRAIN: begin
        if (pair_full && memory_ready) begin
          pair_write        = 1'b1;
          memory_write      = 1'b1;
          memory_address    = BASE_ADDR + 14'd1 + 14'(word_idx);
          memory_writedata  = {pack_hi, pack_lo};
          memory_byteenable = 8'hFF;
        end
        if (state == RUN && flush_cmd)
          state_next = DRAIN;
        else if (state == DRAIN && fifo_empty && !pair_full)
          state_next = PART;
      end
      PART: begin
        if (!have_lo) begin
          state_next = HDR;
        end else if (memory_ready) begin
          part_write        = 1'b1;
          memory_write      = 1'b1;
          memory_address    = BASE_ADDR + 14'd1 + 14'(word_idx);
          memory_writedata  = {32'h0, pack_lo};
          memory_byteenable = 8'h0F;
          state_next        = HDR;
        end
      end
      HDR: begin
        if (memory_ready) begin
          memory_write      = 1'b1;
          memory_address    = BASE_ADDR;
          memory_writedata  = {48'h0, hit_count};
          memory_byteenable = 8'hFF;
          state_next        = DONE;
        end
      end
      default: ;
    endcase
    if (start_cmd)
      state_next = RUN;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr[AW-1:0]] <= record;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pack_lo   <= 32'd0;
      pack_hi   <= 32'd0;
      have_lo   <= 1'b0;
      pair_full <= 1'b0;
      word_idx  <= 16'd0;
      hit_count <= 16'd0;
      overflow  <= 1'b0;
    end else begin
      state <= state_next;
      if (start_cmd) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        have_lo   <= 1'b0;
        pair_full <= 1'b0;
        word_idx  <= 16'd0;
        hit_count <= 16'd0;
        overflow  <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (word_limit) begin
            overflow <= 1'b1;
          end else begin
            if (!have_lo) begin
              pack_lo <= pop_record;
              have_lo <= 1'b1;
            end else begin
              pack_hi   <= pop_record;
              pair_full <= 1'b1;
              have_lo   <= 1'b0;
            end
            if (hit_count != 16'hFFFF)
              hit_count <= hit_count + 16'd1;
          end
        end
        if (pair_write) begin
          pair_full <= 1'b0;
          word_idx  <= word_idx + 16'd1;
        end
        if (part_write)
          have_lo <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blast_hit_writer.sv
// tb/tb_blast_hit_writer.sv - directed self-checking bench for blast_hit_writer
module tb_blast_hit_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        app_ready;
  logic [7:0]  app_code;
  logic        hit_valid;
  logic [31:0] rec;
  logic        memory_ready;

  logic        hit_ready, memory_write, memory_chipselect, memory_clken, busy, done, overflow;
  logic [13:0] memory_address;
  logic [63:0] memory_writedata;
  logic [7:0]  memory_byteenable;
  logic [15:0] hit_count;

  logic        c_hit_ready, c_write, c_cs, c_clken, c_busy, c_done, c_overflow;
  logic [13:0] c_address;
  logic [63:0] c_writedata;
  logic [7:0]  c_byteenable;
  logic [15:0] c_hit_count;

  int checks = 0;
  int failures = 0;

  logic [13:0] wa[$];
  logic [63:0] wd[$];
  logic [7:0]  wb[$];
  logic        wc[$];
  logic [13:0] ca[$];
  logic [63:0] cd[$];
  logic [7:0]  cb[$];

  always #5 clk = ~clk;

  blast_hit_writer dut (
    .clk(clk), .reset(rst), .app_ready(app_ready), .app_code(app_code),
    .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_add_inQ_UnGap(rec[7:0]), .hit_add_inS_UnGap(rec[15:8]),
    .hit_length_UnGap(rec[23:16]), .hit_add_score(rec[31:24]),
    .memory_ready(memory_ready), .memory_address(memory_address), .memory_write(memory_write),
    .memory_writedata(memory_writedata), .memory_byteenable(memory_byteenable),
    .memory_chipselect(memory_chipselect), .memory_clken(memory_clken),
    .hit_count(hit_count), .busy(busy), .done(done), .overflow(overflow)
  );

  blast_hit_writer #(.MAX_WORDS(16'd2)) dut_cap (
    .clk(clk), .reset(rst), .app_ready(app_ready), .app_code(app_code),
    .hit_valid(hit_valid), .hit_ready(c_hit_ready),
    .hit_add_inQ_UnGap(rec[7:0]), .hit_add_inS_UnGap(rec[15:8]),
    .hit_length_UnGap(rec[23:16]), .hit_add_score(rec[31:24]),
    .memory_ready(memory_ready), .memory_address(c_address), .memory_write(c_write),
    .memory_writedata(c_writedata), .memory_byteenable(c_byteenable),
    .memory_chipselect(c_cs), .memory_clken(c_clken),
    .hit_count(c_hit_count), .busy(c_busy), .done(c_done), .overflow(c_overflow)
  );

  always @(negedge clk) begin
    if (memory_write) begin
      wa.push_back(memory_address);
      wd.push_back(memory_writedata);
      wb.push_back(memory_byteenable);
      wc.push_back(memory_chipselect & memory_clken);
    end
    if (c_write) begin
      ca.push_back(c_address);
      cd.push_back(c_writedata);
      cb.push_back(c_byteenable);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wb.delete(); wc.delete();
    ca.delete(); cd.delete(); cb.delete();
  endtask

  task automatic cmd(input logic [7:0] code);
    app_ready = 1'b1;
    app_code  = code;
    tick();
    app_ready = 1'b0;
    app_code  = 8'h00;
  endtask

  task automatic send_hit(input string tag, input logic [31:0] r);
    logic ok;
    ok = 1'b0;
    hit_valid = 1'b1;
    rec = r;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = hit_ready;
      tick();
    end
    hit_valid = 1'b0;
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_done(input string tag, input bit use_cap);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done && (!use_cap || c_done)) break;
    end
    chk(tag, use_cap ? c_done : done, 1'b1);
    tick();
  endtask

  initial begin
    rst = 1'b1; app_ready = 1'b0; app_code = 8'h00;
    hit_valid = 1'b0; rec = 32'h0; memory_ready = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hit_ready", hit_ready, 1'b0);
    chk("rst_write", memory_write, 1'b0);
    chk("rst_count", hit_count, 16'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_addr", memory_address, 14'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: one full pair then header
    clear_log();
    cmd(8'hAA);
    chk("t1_busy", busy, 1'b1);
    send_hit("t1_acc0", 32'hddccbbaa);
    send_hit("t1_acc1", 32'h44332211);
    cmd(8'hBB);
    wait_done("t1_done", 1'b0);
    chk("t1_nwr", wa.size(), 2);
    chk("t1_a0", wa[0], 14'd1);
    chk("t1_d0", wd[0], 64'h44332211_ddccbbaa);
    chk("t1_b0", wb[0], 8'hFF);
    chk("t1_cs0", wc[0], 1'b1);
    chk("t1_a1", wa[1], 14'd0);
    chk("t1_d1", wd[1], 64'd2);
    chk("t1_b1", wb[1], 8'hFF);
    chk("t1_count", hit_count, 16'd2);
    repeat (3) tick();
    chk("t1_done_held", done, 1'b1);
    chk("t1_busy_off", busy, 1'b0);

    // 2: odd hit goes out as a half word
    clear_log();
    cmd(8'hAA);
    chk("t2_done_clr", done, 1'b0);
    send_hit("t2_acc0", 32'h14131211);
    send_hit("t2_acc1", 32'h24232221);
    send_hit("t2_acc2", 32'h34333231);
    cmd(8'hBB);
    wait_done("t2_done", 1'b0);
    chk("t2_nwr", wa.size(), 3);
    chk("t2_a0", wa[0], 14'd1);
    chk("t2_d0", wd[0], 64'h24232221_14131211);
    chk("t2_a1", wa[1], 14'd2);
    chk("t2_d1", wd[1], 64'h00000000_34333231);
    chk("t2_b1", wb[1], 8'h0F);
    chk("t2_a2", wa[2], 14'd0);
    chk("t2_d2", wd[2], 64'd3);

    // 3: memory stalled, storage fills, then everything drains in order
    clear_log();
    memory_ready = 1'b0;
    cmd(8'hAA);
    for (int i = 1; i <= 6; i++) send_hit("t3_acc", 32'h50000000 + 32'(i));
    repeat (12) tick();
    chk("t3_nostrobe", wa.size(), 0);
    @(negedge clk);
    chk("t3_ready_low", hit_ready, 1'b0);
    tick();
    memory_ready = 1'b1;
    cmd(8'hBB);
    wait_done("t3_done", 1'b0);
    chk("t3_nwr", wa.size(), 4);
    chk("t3_a0", wa[0], 14'd1);
    chk("t3_d0", wd[0], 64'h50000002_50000001);
    chk("t3_a1", wa[1], 14'd2);
    chk("t3_d1", wd[1], 64'h50000004_50000003);
    chk("t3_a2", wa[2], 14'd3);
    chk("t3_d2", wd[2], 64'h50000006_50000005);
    chk("t3_hdr", wd[3], 64'd6);

    // 4: capacity limit on the MAX_WORDS=2 instance
    clear_log();
    cmd(8'hAA);
    for (int i = 1; i <= 6; i++) send_hit("t4_acc", 32'h60000000 + 32'(i));
    cmd(8'hBB);
    wait_done("t4_done", 1'b1);
    chk("t4_nwr", ca.size(), 3);
    chk("t4_a0", ca[0], 14'd1);
    chk("t4_d0", cd[0], 64'h60000002_60000001);
    chk("t4_a1", ca[1], 14'd2);
    chk("t4_d1", cd[1], 64'h60000004_60000003);
    chk("t4_a2", ca[2], 14'd0);
    chk("t4_hdr", cd[2], 64'd4);
    chk("t4_ovf", c_overflow, 1'b1);
    chk("t4_count", c_hit_count, 16'd4);
    chk("t4_ovf_big", overflow, 1'b0);

    // 5: hit on the flush cycle is kept, the next one is refused
    clear_log();
    cmd(8'hAA);
    chk("t5_ovf_clr", c_overflow, 1'b0);
    send_hit("t5_acc0", 32'h64636261);
    hit_valid = 1'b1; rec = 32'h74737271;
    app_ready = 1'b1; app_code = 8'hBB;
    @(negedge clk);
    chk("t5_ready_flush", hit_ready, 1'b1);
    tick();
    app_ready = 1'b0; app_code = 8'h00; rec = 32'h84838281;
    @(negedge clk);
    chk("t5_ready_after", hit_ready, 1'b0);
    tick();
    hit_valid = 1'b0;
    wait_done("t5_done", 1'b0);
    chk("t5_count", hit_count, 16'd2);
    chk("t5_nwr", wa.size(), 2);
    chk("t5_d0", wd[0], 64'h74737271_64636261);
    chk("t5_hdr", wd[1], 64'd2);

    // 6: reset drops a live strobe; START mid-run restarts at word 1
    clear_log();
    memory_ready = 1'b0;
    cmd(8'hAA);
    send_hit("t6_acc0", 32'h71000001);
    send_hit("t6_acc1", 32'h71000002);
    repeat (3) tick();
    memory_ready = 1'b1;
    #2;
    chk("t6_pre_write", memory_write, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_write", memory_write, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_count", hit_count, 16'd0);
    chk("t6_rst_ready", hit_ready, 1'b0);
    tick();
    rst = 1'b0;
    cmd(8'hAA);
    for (int i = 1; i <= 3; i++) send_hit("t6_acc", 32'h72000000 + 32'(i));
    repeat (3) tick();
    chk("t6_count3", hit_count, 16'd3);
    cmd(8'hAA);
    chk("t6_count0", hit_count, 16'd0);
    clear_log();
    send_hit("t6_accA", 32'h73000001);
    send_hit("t6_accB", 32'h73000002);
    repeat (4) tick();
    chk("t6_nwr", wa.size(), 1);
    chk("t6_a0", wa[0], 14'd1);
    chk("t6_d0", wd[0], 64'h73000002_73000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
